// File: rtl/uart_tx_prescaled_pkg.sv
// Shared constants for the prescaled UART transmitter: FSM encodings,
// minimum bit period and the prescale clamp helper.
package uart_tx_prescaled_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  // Shortest bit period; smaller Prescale values are stretched to this.
  localparam logic [4:0] MIN_PRESCALE = 5'd4;

  // Frame FSM, 3-bit binary encoding shared with the receiver.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic [4:0] eff_prescale(input logic [4:0] ps);
    return (ps < MIN_PRESCALE) ? MIN_PRESCALE : ps;
  endfunction

endpackage

// File: rtl/uart_tx_prescaled_if.sv
// Parallel request side and serial line of the transmitter.
interface uart_tx_prescaled_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [4:0]            Prescale;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_prescaled_bit_timer.sv
// Bit-period timer: latches the clamped prescale at frame accept and
// pulses bit_done_o on the last cycle of every bit period.
module uart_tx_bit_timer
  import uart_tx_prescaled_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       load_i,      // frame accepted this cycle
  input  logic [4:0] prescale_i,  // raw Prescale from the bus
  input  logic       run_i,       // a frame is in flight
  output logic       bit_done_o
);

  logic [4:0] per_q, per_d;
  logic [4:0] cnt_q, cnt_d;
  logic       last;

  // Counter runs 0..P-1; P never exceeds 31 so 5 bits cannot overflow.
  assign last       = (cnt_q == per_q - 5'd1);
  assign bit_done_o = run_i && last;

  // Next-state for the period latch and the bit-period counter.
  always_comb begin
    per_d = per_q;
    cnt_d = cnt_q;
    if (load_i) begin
      per_d = eff_prescale(prescale_i);
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = last ? 5'd0 : cnt_q + 5'd1;
    end
  end

  // State registers; reset leaves the counter idle at zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      per_q <= MIN_PRESCALE;
      cnt_q <= '0;
    end else begin
      per_q <= per_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_prescaled.sv
// UART transmitter on the shared oversampled clock: start bit, data LSB
// first, optional parity, one stop bit, each lasting max(Prescale,4) cycles.
module uart_tx_prescaled
  import uart_tx_prescaled_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  uart_tx_prescaled_if.slave bus
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  logic [2:0]            state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  accept;
  logic                  bit_done;

  assign accept = (state_q == S_IDLE) && bus.Data_Valid;

  uart_tx_bit_timer u_timer (
    .CLK        (CLK),
    .RST        (RST),
    .load_i     (accept),
    .prescale_i (bus.Prescale),
    .run_i      (state_q != S_IDLE),
    .bit_done_o (bit_done)
  );

  // Frame FSM; the line value for the next bit is decided one cycle ahead
  // so TX_OUT stays a plain register.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.Data_Valid) begin
          state_d   = S_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          shift_d   = bus.P_DATA;
          idx_d     = '0;
          par_en_d  = bus.PAR_EN;
          par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Registered frame state; reset forces the line high at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_prescaled.sv
// Directed bench for uart_tx_prescaled: frames are sampled every cycle and
// compared with hand-written line patterns {stop, parity, data, start}.
module tb_uart_tx_prescaled;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;
  int   stop_cyc = 0;

  uart_tx_prescaled_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_prescaled #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Sends one frame (or picks up one already armed by a held Data_Valid)
  // and checks start latency, every line sample, busy length and idle.
  task automatic run_frame(input string tag, input logic [7:0] d, input bit pe, input bit pt,
                           input logic [4:0] ps, input logic [10:0] exp_v,
                           input bit hold, input bit pre_armed);
    int p, nb, errs, blen;
    logic [10:0] got, mask;
    p    = (ps < 5'd4) ? 4 : int'(ps);
    nb   = pe ? 11 : 10;
    errs = 0;
    blen = 0;
    got  = '0;
    mask = 11'((1 << nb) - 1);
    if (!pre_armed) begin
      @(negedge CLK);
      bus.P_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt;
      bus.Prescale = ps; bus.Data_Valid = 1'b1;
    end
    @(posedge CLK); #1;
    if (pre_armed) chk({tag, "_gap"}, cyc - stop_cyc, p + 1);
    chk({tag, "_start"}, {bus.busy, bus.TX_OUT}, 2'b10);
    // Disturb latched inputs; the frame in flight must not notice.
    bus.P_DATA = ~d;
    if (!hold) begin
      bus.Data_Valid = 1'b0;
      bus.PAR_TYP = ~pt; bus.PAR_EN = ~pe; bus.Prescale = ps ^ 5'h0A;
    end
    for (int c = 0; c < nb * p; c++) begin
      if (c > 0) begin @(posedge CLK); #1; end
      if (bus.TX_OUT !== exp_v[c / p]) errs++;
      if (bus.busy === 1'b1) blen++;
      if (c % p == p / 2) got[c / p] = bus.TX_OUT;
      if (c == (nb - 1) * p) stop_cyc = cyc;
    end
    chk({tag, "_bits"}, got & mask, exp_v & mask);
    chk({tag, "_hold"}, errs, 0);
    chk({tag, "_busylen"}, blen, nb * p);
    @(posedge CLK); #1;
    chk({tag, "_idle"}, {bus.busy, bus.TX_OUT}, 2'b01);
  endtask

  initial begin
    logic [7:0] d;
    bit pe, pt;
    bus.P_DATA = '0; bus.Data_Valid = 1'b0; bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0; bus.Prescale = 5'd8;
    #23;
    chk("reset", {bus.busy, bus.TX_OUT}, 2'b01);
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(posedge CLK);

    // 0xA5 even parity: line 0,1,0,1,0,0,1,0,1,0,1
    run_frame("a5_even", 8'hA5, 1, 0, 5'd8,  11'b1_0_10100101_0, 0, 0);
    // 0x07 odd parity: three ones -> parity 0
    run_frame("07_odd",  8'h07, 1, 1, 5'd8,  11'b1_0_00000111_0, 0, 0);
    // 0x00 no parity at P=16: 160 cycles
    run_frame("00_nopar", 8'h00, 0, 0, 5'd16, 11'b0_1_00000000_0, 0, 0);
    // Prescale=2 clamps to 4: 44 cycles
    run_frame("ps2", 8'h81, 1, 0, 5'd2, 11'b1_0_10000001_0, 0, 0);
    // Prescale=31, 0xFF odd parity -> 1
    run_frame("ps31", 8'hFF, 1, 1, 5'd31, 11'b1_1_11111111_0, 0, 0);

    // Held Data_Valid: 0x3C then 0xC3 back to back, one idle cycle between
    run_frame("b2b_1", 8'h3C, 0, 0, 5'd8, 11'b0_1_00111100_0, 1, 0);
    run_frame("b2b_2", 8'hC3, 0, 0, 5'd8, 11'b0_1_11000011_0, 0, 1);

    // Reset halfway through DATA aborts the frame asynchronously
    @(negedge CLK);
    bus.P_DATA = 8'h55; bus.PAR_EN = 1'b0; bus.Prescale = 5'd8; bus.Data_Valid = 1'b1;
    @(posedge CLK); #1;
    bus.Data_Valid = 1'b0;
    repeat (8 + 4 * 8) @(posedge CLK);
    #3;
    chk("pre_rst_busy", bus.busy, 1'b1);
    RST = 1'b0;
    #1;
    chk("async_rst", {bus.busy, bus.TX_OUT}, 2'b01);
    @(negedge CLK); RST = 1'b1;
    run_frame("55_after_rst", 8'h55, 0, 0, 5'd8, 11'b0_1_01010101_0, 0, 0);

    // Random words with random parity settings; expectation built per word
    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      run_frame($sformatf("rnd%0d", i), d, pe, pt, 5'd8,
                pe ? {1'b1, (^d) ^ pt, d, 1'b0} : {1'b0, 1'b1, d, 1'b0}, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
